snake_game_ctrl: RTL
====================

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 6: frame_start pulses counted per snake step.
REQ-002 SHALL have parameter MAX_SIZE, default 16: maximum snake length in segments.
REQ-003 SHALL have parameter INI_LEN, default 3: snake length after reset or restart.
REQ-004 SHALL have port pixel_clk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port key  in  4  raw buttons, active-high: [0] up, [1] down, [2] left, [3] right.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse from the timing generator, once per video frame.
REQ-008 SHALL have port step_done  in  1  one-cycle pulse from the snake datapath when a requested step is finished.
REQ-009 SHALL have port wall_hit, self_hit, food_hit  in  1 each  datapath result flags, valid only when step_done=1.
REQ-010 SHALL have port step_req  out  1  one-cycle pulse commanding the datapath to move the snake by one block.
REQ-011 SHALL have port step_dir  out  2  direction for the step, valid while step_req=1: 0 up, 1 down, 2 left, 3 right.
REQ-012 SHALL have port grow  out  1  one-cycle pulse telling the datapath to keep its tail (length +1).
REQ-013 SHALL have port restart  out  1  one-cycle pulse telling the datapath to reload the initial snake and food.
REQ-014 SHALL have port snake_len  out  5  current length, for draw masking.
REQ-015 SHALL have port score  out  8  food eaten since the last restart.
REQ-016 SHALL have port game_state  out  2  game state: 0 IDLE, 1 RUN, 2 STEP, 3 OVER.

Function
REQ-017 SHALL pass key through a 2-flop synchronizer plus a rising-edge detector, giving a one-cycle press pulse 3 cycles after the raw rising edge.
REQ-018 SHALL, when press pulses coincide, accept only the highest-priority one: key[0] > key[1] > key[2] > key[3].
REQ-019 SHALL hold a committed direction (cur_dir) and a pending direction (nxt_dir); a press sets nxt_dir unless it is the reverse of cur_dir (up/down, left/right), in which case the press is discarded.
REQ-020 SHALL implement the state machine below.
REQ-021 IDLE: the first accepted press sets nxt_dir and enters RUN with the frame counter at 0; a press equal to the reverse of the reset direction (left) is still discarded.
REQ-022 RUN: count frame_start pulses; on pulse number FRAMES_PER_STEP, in that same cycle, assert step_req with step_dir=nxt_dir, set cur_dir<=nxt_dir, clear the counter and enter STEP.
REQ-023 STEP: wait for step_done with no timeout; frame_start pulses are ignored. On step_done:
 - wall_hit or self_hit -> OVER (this takes priority over food_hit);
 - else food_hit -> pulse grow next cycle, snake_len+1 saturating at MAX_SIZE, score+1 saturating at 255, then RUN;
 - else -> RUN.
REQ-024 A press that arrives in the step_req cycle SHALL be checked against the newly committed direction and take effect at the next step.
REQ-025 Only the last accepted press before a step SHALL be applied to that step; intermediate presses are overwritten.
REQ-026 OVER: outputs hold; any press -> IDLE with a restart pulse; in that cycle snake_len<=INI_LEN, score<=0, cur_dir=nxt_dir<=right.
REQ-027 step_done received outside STEP SHALL be ignored.
REQ-028 step_req SHALL never be asserted again until the outstanding step_done has been received.

Reset
REQ-029 On sys_rst=1 at a clock edge, all state SHALL clear regardless of current state, including mid-STEP:
 - game_state=IDLE, cur_dir=nxt_dir=right (3), frame counter=0;
 - snake_len=INI_LEN, score=0;
 - step_req=grow=restart=0;
 - synchronizer and edge-detector flops=0.
REQ-030 A key held high through reset SHALL NOT produce a press pulse after reset is released.

Structure
REQ-031 Package snake_pkg SHALL hold the direction encodings, game_state encodings, MAX_SIZE, INI_LEN and BLOCK_W, shared with the datapath and draw blocks.
REQ-032 Sub-module key_edge (4-bit synchronizer plus rising-edge detector) SHALL be instantiated once.

Verification
REQ-033 Reset, then press key[3] once -> RUN; after 6 frame_start pulses, step_req=1 with step_dir=3 in the cycle of the 6th pulse.
REQ-034 In RUN with cur_dir=3, press key[2] -> discarded, next step_dir=3; then press key[0] -> next step_dir=0.
REQ-035 step_done with food_hit=1 -> grow pulse one cycle later, snake_len 3->4, score 0->1; 13 consecutive food hits from reset -> snake_len holds at 16.
REQ-036 step_done with wall_hit=1 and food_hit=1 together -> OVER, score unchanged, no grow pulse; then any press -> restart pulse, game_state=IDLE, snake_len=3.
REQ-037 Assert sys_rst for one cycle while in STEP, then send step_done -> game_state=IDLE, no step_req, and the step_done is ignored.
REQ-038 Hold key[1] high across reset release -> no state change until key[1] falls and rises again.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Encodings and sizing constants shared by the snake game
//               controller, datapath and draw blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  // Step directions, as carried on step_dir
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Top-level game states, as carried on game_state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam int MAX_SIZE = 16;  // longest snake, in segments
  localparam int INI_LEN  = 3;   // length after reset or restart
  localparam int BLOCK_W  = 16;  // pixel width of one grid block

  // Up/down and left/right pairs differ only in bit 0
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_edge
// Description : Two-flop synchronizer plus rising-edge detector for raw push
//               buttons; emits a registered one-cycle press pulse per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] key_i,
  output logic [WIDTH-1:0] press_o
);
  import snake_pkg::*;

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] armed_q;
  logic [WIDTH-1:0] press_q;
  logic [1:0]       valid_q;

  // Synchronize, detect rising edges, and only arm a bit once the synchronized
  // key has been seen low after reset so a held key cannot fake a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      press_q <= '0;
      valid_q <= '0;
    end else begin
      meta_q  <= key_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      valid_q <= {valid_q[0], 1'b1};
      if (valid_q[1]) begin
        armed_q <= armed_q | ~sync_q;
      end
      press_q <= sync_q & ~prev_q & armed_q;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_game_ctrl
// Description : Snake game controller. Turns button presses into a pending
//               direction, paces steps from frame pulses, and tracks length,
//               score and game-over/restart around the snake datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_game_ctrl #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int MAX_SIZE        = 16,
  parameter int INI_LEN         = 3
) (
  input  logic       pixel_clk,
  input  logic       sys_rst,
  input  logic [3:0] key,
  input  logic       frame_start,
  input  logic       step_done,
  input  logic       wall_hit,
  input  logic       self_hit,
  input  logic       food_hit,
  output logic       step_req,
  output logic [1:0] step_dir,
  output logic       grow,
  output logic       restart,
  output logic [4:0] snake_len,
  output logic [7:0] score,
  output logic [1:0] game_state
);
  import snake_pkg::*;

  localparam int               c_cnt_w    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAMES_PER_STEP - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [4:0]       c_len_ini  = 5'(INI_LEN);
  localparam logic [4:0]       c_len_max  = 5'(MAX_SIZE);
  localparam logic [7:0]       c_score_max = 8'd255;

  logic [3:0]         w_press;
  logic               w_press_vld;
  dir_e               w_press_dir;
  logic               w_step_req;
  logic               w_restart;

  game_state_e        state_q,   state_d;
  dir_e               cur_dir_q, cur_dir_d;
  dir_e               nxt_dir_q, nxt_dir_d;
  logic [c_cnt_w-1:0] frame_cnt_q, frame_cnt_d;
  logic [4:0]         len_q,     len_d;
  logic [7:0]         score_q,   score_d;
  logic               grow_q,    grow_d;

  key_edge #(
    .WIDTH (4)
  ) u_key_edge (
    .clk_i   (pixel_clk),
    .rst_i   (sys_rst),
    .key_i   (key),
    .press_o (w_press)
  );

  // Keep only the highest-priority press when several coincide
  always_comb begin
    w_press_vld = |w_press;
    w_press_dir = DIR_UP;
    if (w_press[0])      w_press_dir = DIR_UP;
    else if (w_press[1]) w_press_dir = DIR_DOWN;
    else if (w_press[2]) w_press_dir = DIR_LEFT;
    else if (w_press[3]) w_press_dir = DIR_RIGHT;
  end

  // Game state machine: next state, direction bookkeeping and step pacing
  always_comb begin
    state_d     = state_q;
    cur_dir_d   = cur_dir_q;
    nxt_dir_d   = nxt_dir_q;
    frame_cnt_d = frame_cnt_q;
    len_d       = len_q;
    score_d     = score_q;
    grow_d      = 1'b0;
    w_step_req  = 1'b0;
    w_restart   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_press_vld && (w_press_dir != reverse_dir(cur_dir_q))) begin
          nxt_dir_d   = w_press_dir;
          frame_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_start) begin
          if (frame_cnt_q == c_cnt_last) begin
            w_step_req  = 1'b1;
            cur_dir_d   = nxt_dir_q;
            frame_cnt_d = '0;
            state_d     = ST_STEP;
          end else begin
            frame_cnt_d = frame_cnt_q + c_cnt_one;
          end
        end
        // A press in the step cycle is judged against the direction being committed
        if (w_press_vld && (w_press_dir != reverse_dir(cur_dir_d))) begin
          nxt_dir_d = w_press_dir;
        end
      end
      ST_STEP: begin
        if (w_press_vld && (w_press_dir != reverse_dir(cur_dir_q))) begin
          nxt_dir_d = w_press_dir;
        end
        if (step_done) begin
          if (wall_hit || self_hit) begin
            state_d = ST_OVER;
          end else begin
            if (food_hit) begin
              grow_d = 1'b1;
              if (len_q < c_len_max)     len_d   = len_q + 5'd1;
              if (score_q != c_score_max) score_d = score_q + 8'd1;
            end
            state_d = ST_RUN;
          end
        end
      end
      ST_OVER: begin
        if (w_press_vld) begin
          w_restart   = 1'b1;
          len_d       = c_len_ini;
          score_d     = '0;
          cur_dir_d   = DIR_RIGHT;
          nxt_dir_d   = DIR_RIGHT;
          frame_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cur_dir_q   <= DIR_RIGHT;
      nxt_dir_q   <= DIR_RIGHT;
      frame_cnt_q <= '0;
      len_q       <= c_len_ini;
      score_q     <= '0;
      grow_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dir_q   <= cur_dir_d;
      nxt_dir_q   <= nxt_dir_d;
      frame_cnt_q <= frame_cnt_d;
      len_q       <= len_d;
      score_q     <= score_d;
      grow_q      <= grow_d;
    end
  end

  // Command pulses are suppressed while reset is applied
  assign step_req   = w_step_req & ~sys_rst;
  assign restart    = w_restart & ~sys_rst;
  assign step_dir   = nxt_dir_q;
  assign grow       = grow_q;
  assign snake_len  = len_q;
  assign score      = score_q;
  assign game_state = state_q;

endmodule
`default_nettype wire
